// File: rtl/bitfuscnn_pkg.sv
// Shared encodings and helpers for the sparse operand path.
package bitfuscnn_pkg;

  localparam logic [1:0] BW_16 = 2'b00;
  localparam logic [1:0] BW_8  = 2'b01;
  localparam logic [1:0] BW_4  = 2'b10;

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] MAX_DELTA = 4'd15;

  // Reserved mode 2'b11 falls back to the full 16-lane group.
  function automatic logic [4:0] lanes_for_bitwidth(input logic [1:0] bw);
    case (bw)
      BW_8:    return 5'd8;
      BW_4:    return 5'd4;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/sparse_delta_calc.sv
// Combinational delta and emit decision for one dense element.
module sparse_delta_calc
  import bitfuscnn_pkg::*;
(
  input  logic [IDX_W-1:0] i_gap,
  input  logic             i_slot_zero,
  input  logic             i_first,
  input  logic             i_nonzero,
  output logic [IDX_W-1:0] o_delta,
  output logic             o_emit,
  output logic             o_pad
);

  logic w_at_max;

  // Slot 0 of a continuing tile is measured from the previous group's last entry.
  assign o_delta  = (i_slot_zero && !i_first) ? i_gap + 4'd1 : i_gap;
  assign w_at_max = (o_delta == MAX_DELTA);
  assign o_emit   = i_nonzero || w_at_max;
  assign o_pad    = w_at_max && !i_nonzero;

endmodule

// File: rtl/sparse_index_encoder.sv
// Dense-to-sparse encoder: packs non-zero elements and 4-bit relative indices into groups.
module sparse_index_encoder
  import bitfuscnn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [1:0]                        bitwidth,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES-1:0][DATA_W-1:0]      out_values,
  output logic [LANES-1:0][IDX_W-1:0]       out_indices,
  output logic [4:0]                        out_count,
  output logic                              out_last
);

  logic [IDX_W-1:0]              r_gap;
  logic [4:0]                    r_slot;
  logic                          r_first;
  logic                          r_tile_start;
  logic [1:0]                    r_bw;
  logic [LANES-1:0][DATA_W-1:0]  r_asm_val;
  logic [LANES-1:0][IDX_W-1:0]   r_asm_idx;

  logic                          w_accept;
  logic [IDX_W-1:0]              w_delta;
  logic                          w_emit;
  logic                          w_pad;
  logic [4:0]                    w_group_lanes;
  logic [4:0]                    w_fill;
  logic                          w_close;
  logic [LANES-1:0][DATA_W-1:0]  w_grp_val;
  logic [LANES-1:0][IDX_W-1:0]   w_grp_idx;

  // Handshake: an element is taken when in_valid && in_ready; a group is
  // taken when out_valid && out_ready, and the output register can refill
  // on the same edge it retires.
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  sparse_delta_calc u_delta (
    .i_gap       (r_gap),
    .i_slot_zero (r_slot == 5'd0),
    .i_first     (r_first),
    .i_nonzero   (in_data != '0),
    .o_delta     (w_delta),
    .o_emit      (w_emit),
    .o_pad       (w_pad)
  );

  // The first element of a tile uses the live mode, later ones the latched copy.
  assign w_group_lanes = lanes_for_bitwidth(r_tile_start ? bitwidth : r_bw);
  assign w_fill        = r_slot + 5'(w_emit);
  assign w_close       = w_accept && (in_last || (w_fill == w_group_lanes));

  always_comb begin
    w_grp_val = '0;
    w_grp_idx = '0;
    for (int i = 0; i < LANES; i++) begin
      if (5'(i) < r_slot) begin
        w_grp_val[i] = r_asm_val[i];
        w_grp_idx[i] = r_asm_idx[i];
      end else if ((5'(i) == r_slot) && w_emit) begin
        w_grp_val[i] = w_pad ? '0 : in_data;
        w_grp_idx[i] = w_delta;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gap        <= '0;
      r_slot       <= '0;
      r_first      <= 1'b1;
      r_tile_start <= 1'b1;
      r_bw         <= BW_16;
      r_asm_val    <= '0;
      r_asm_idx    <= '0;
      out_valid    <= 1'b0;
      out_values   <= '0;
      out_indices  <= '0;
      out_count    <= '0;
      out_last     <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_close) begin
        out_valid   <= 1'b1;
        out_values  <= w_grp_val;
        out_indices <= w_grp_idx;
        out_count   <= w_fill;
        out_last    <= in_last;
      end
      if (w_accept) begin
        if (r_tile_start) begin
          r_bw <= bitwidth;
        end
        r_tile_start <= 1'b0;
        if (w_emit) begin
          r_asm_val[r_slot[3:0]] <= in_data;
          r_asm_idx[r_slot[3:0]] <= w_delta;
          r_gap                  <= '0;
          r_first                <= 1'b0;
        end else begin
          r_gap <= r_gap + 4'd1;
        end
        if (w_close) begin
          r_slot <= '0;
        end else if (w_emit) begin
          r_slot <= w_fill;
        end
        if (in_last) begin
          r_gap        <= '0;
          r_first      <= 1'b1;
          r_tile_start <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/sparse_index_encoder.md
# sparse_index_encoder

Compresses a dense, zero-rich stream of activations or weights into the run-length-indexed sparse format used by the PE array: groups of non-zero values plus 4-bit relative indices. Sits between the dense tile buffers and the sparse operand FIFOs. It is the exact inverse of the index decoding done in coordinate computation: feeding its `out_indices` into that decoder reproduces the original absolute positions.

## Interface
- `DATA_W`, default 16: element width in bits.
- `LANES`, default 16: maximum entries per output group.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `bitwidth`  in  2  group-size mode: 00 = 16 lanes, 01 = 8, 10 = 4; 11 is reserved and treated as 00. Latched on the first accepted element of a tile.
- `in_valid`  in  1  dense element valid.
- `in_ready`  out  1  element accepted when `in_valid && in_ready`.
- `in_data`  in  DATA_W  dense element, in raster order.
- `in_last`  in  1  final element of the tile.
- `out_valid`  out  1  group valid.
- `out_ready`  in  1  downstream accepts the group.
- `out_values`  out  LANES x DATA_W  compressed values, in slot order.
- `out_indices`  out  LANES x 4  relative indices.
- `out_count`  out  5  number of valid slots, 0..16.
- `out_last`  out  1  group closes the tile.

## Operation
- State: `L`, the absolute index of the last emitted entry (reset 0). `gap`, the number of zeros since the last emission. `slot`, the next slot in the assembly buffer. `first`, set at tile start.
- For each accepted element, the candidate delta `d` is:
  - `gap` if `first`;
  - `gap+1` if `slot==0` and not `first`;
  - `gap` otherwise.
- Emit rule: emit when `in_data != 0`, or when `d == 15` (padding entry with value 0). An emission writes the value and `d` into `slot`, advances `slot`, clears `gap`, and clears `first`. A non-emitted zero increments `gap`.
- Decode identity the verifier checks:
  - slot 0 absolute index = previous group's last index + delta;
  - slot i>0 absolute index = previous index + delta + 1;
  - the first group of a tile starts from 0.
- Group close: happens when `slot` reaches the group size from `bitwidth`, or on `in_last`, whichever comes first. Closing loads the output register with the assembly contents plus the current entry, sets `out_count`, and sets `out_last = in_last`. Unused slots are driven with value 0 and index 0.
- On `in_last`: the group always closes, even when it has zero entries (`out_count=0`, `out_last=1`). All of `slot`, `gap`, `L` and `first` are then reinitialised for the next tile.
- Changing `bitwidth` mid-tile has no effect until the next tile.

## Timing
- `in_ready = !out_valid || out_ready`. This is combinational from registered `out_valid` and the input `out_ready`. At most one element is accepted per cycle.
- Latency: `out_valid` rises the cycle after the handshake of the closing element. Back-to-back groups are possible at full rate when `out_ready` is held high.
- An output group is held stable (all `out_*` fields) while `out_valid && !out_ready`.
- Simultaneous `out_ready` and a closing element in the same cycle: the old group retires and the new group loads on the same edge, with no bubble.
- Reset, asynchronous and taking effect mid-operation:
  - `in_ready`: 1.
  - `out_valid`: 0.
  - `out_values`, `out_indices`, `out_count`, `out_last`: 0.
  - `L`, `gap`, `slot`: 0.
  - `first`: 1.
  - latched bitwidth: 00.
  - Any partially assembled group is discarded.

## Structure
- Shared package `bitfuscnn_pkg`:
  - bitwidth mode encodings (`BW_16`, `BW_8`, `BW_4`);
  - an index-width constant of 4 with `MAX_DELTA = 15`;
  - a `lanes_for_bitwidth()` function returning 16/8/4.
- One sub-module, `sparse_delta_calc`. It is combinational: from `gap`, `slot==0` and `first` it produces `d`, the emit flag and the pad flag. The top level keeps the counters, the assembly buffer, the output register and the handshake.

## Test plan
- Four-lane mode (`bitwidth=10`), input 0,5,0,0,7,3,0,9 with `last` on the 9 -> one group: values {5,7,3,9}, indices {1,2,0,1}, count 4, `out_last=1`.
- Four-lane mode, input 1,2,3,4,0,0,8 with `last` -> first group: values {1,2,3,4}, indices {0,0,0,0}, count 4, `out_last=0`. Second group: values {8,0,0,0}, indices {3,0,0,0}, count 1, `out_last=1`.
- Sixteen-lane mode, 20 zeros then 5 with `last` -> values {0,5}, indices {15,4}, count 2, `out_last=1`. The padding entry sits at absolute index 15; the 5 decodes to absolute index 20.
- Backpressure: fill a 4-lane group, hold `out_ready=0` for 5 cycles -> `in_ready=0` throughout, outputs unchanged. Then raise `out_ready` -> retire and reload with no lost element.
- Single zero element with `last` -> count 0, `out_last=1`, all slots 0. The next tile restarts with `first` set, so an element 3 at index 0 gives index 0.
- Assert `reset_n` low mid-group after 2 emissions -> the next cycle shows `out_valid=0` and `in_ready=1`. A fresh tile then encodes as if from power-up.
